// File: rtl/uart_rx_pkg.sv
// Shared constants and state encoding for the UART receive path
// (FSM, data sampler, start/parity/stop checkers).
package uart_rx_pkg;

    // Bit indices within a frame, as counted by edge_bit_counter.
    localparam int START_BIT = 0;
    localparam int LAST_DATA = 8;
    localparam int PAR_BIT   = 9;

    // Edges after mid-bit at which the sampled bit is stable.
    localparam int CHK_OFS = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Bundle between the receive FSM and its datapath: edge/bit counter,
// sampler, deserializer and the start/parity/stop checkers.
interface uart_rx_fsm_if #(
    parameter int PRESC_W = 6,
    parameter int BITC_W  = 4
);
    // Strobes are level signals sampled on CLK; no backpressure exists,
    // so every strobe is a single-cycle command the datapath must accept.
    logic               edge_bit_en;
    logic               dat_samp_en;
    logic               deser_en;
    logic               strt_chk_en;
    logic               par_chk_en;
    logic               stp_chk_en;
    logic               data_valid;
    logic               frame_err;
    logic [PRESC_W-1:0] edge_cnt;
    logic [BITC_W-1:0]  bit_cnt;
    logic               strt_glitch;
    logic               par_err;
    logic               stp_err;
    uart_rx_pkg::state_t state_dbg;

    modport master (
        output edge_bit_en, dat_samp_en, deser_en, strt_chk_en,
               par_chk_en, stp_chk_en, data_valid, frame_err, state_dbg,
        input  edge_cnt, bit_cnt, strt_glitch, par_err, stp_err
    );

    modport slave (
        input  edge_bit_en, dat_samp_en, deser_en, strt_chk_en,
               par_chk_en, stp_chk_en, data_valid, frame_err, state_dbg,
        output edge_cnt, bit_cnt, strt_glitch, par_err, stp_err
    );

endinterface

// File: rtl/uart_rx_fsm.sv
// Control FSM of the UART receiver: walks start/data/parity/stop bits using
// edge_bit_counter and qualifies each frame with data_valid or frame_err.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = 6,
    parameter int BITC_W  = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic               PAR_EN,
    input  logic [PRESC_W-1:0] Prescale,
    uart_rx_fsm_if.master      rx
);

    state_t             state;
    logic               err;
    logic               data_valid_q;
    logic               frame_err_q;
    logic [PRESC_W-1:0] last_edge;
    logic [PRESC_W-1:0] chk_edge;
    logic [PRESC_W-1:0] glitch_edge;
    logic               at_last;
    logic               at_chk;

    assign last_edge   = Prescale - PRESC_W'(1);
    assign chk_edge    = (Prescale >> 1) + PRESC_W'(CHK_OFS);
    assign glitch_edge = chk_edge + PRESC_W'(1);
    assign at_last     = (rx.edge_cnt == last_edge);
    assign at_chk      = (rx.edge_cnt == chk_edge);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            err          <= 1'b0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!RX_IN) state <= START;
                end
                START: begin
                    // Glitch abort wins over LAST when they coincide (Prescale=8).
                    if ((rx.edge_cnt == glitch_edge) && rx.strt_glitch) state <= IDLE;
                    else if (at_last)                                  state <= DATA;
                end
                DATA: begin
                    if ((rx.bit_cnt == BITC_W'(LAST_DATA)) && at_last)
                        state <= PAR_EN ? PARITY : STOP;
                end
                PARITY: begin
                    if (at_last) begin
                        err   <= rx.par_err;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (at_last) begin
                        if (err || rx.stp_err) frame_err_q  <= 1'b1;
                        else                   data_valid_q <= 1'b1;
                        err   <= 1'b0;
                        state <= RX_IN ? IDLE : START;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rx.edge_bit_en = (state != IDLE);
    assign rx.dat_samp_en = (state != IDLE);
    assign rx.strt_chk_en = (state == START)  && at_chk;
    assign rx.deser_en    = (state == DATA)   && at_chk;
    assign rx.par_chk_en  = (state == PARITY) && at_chk;
    assign rx.stp_chk_en  = (state == STOP)   && at_chk;
    assign rx.data_valid  = data_valid_q;
    assign rx.frame_err   = frame_err_q;
    assign rx.state_dbg   = state;

endmodule
